// File: rtl/hazard3_ahb_dma.sv
// Single-channel memory-to-memory DMA: APB register file plus AHB-Lite master, one beat in flight.
// Latency: 4 cycles per beat on a zero-wait bus (RD_A, RD_D, WR_A, WR_D), plus one per hready-low cycle.
// Backpressure: AHB hready stalls the current phase; the APB side is zero-wait with pslverr on rejected writes.
// Ports: clk/rst_n; AHB-Lite master (haddr..hrdata); APB slave (psel..pslverr); irq level interrupt.
module hazard3_ahb_dma #(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int W_COUNT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [W_ADDR-1:0] haddr,
    output logic              hwrite,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    input  logic              hready,
    input  logic              hresp,
    output logic [W_DATA-1:0] hwdata,
    input  logic [W_DATA-1:0] hrdata,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [15:0]       paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_D = 3'd2,
        S_WR_A = 3'd3,
        S_WR_D = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [W_ADDR-1:0]   src_q, src_d, dst_q, dst_d;
    logic [W_COUNT-1:0]  count_q, count_d, remain_q, remain_d;
    logic                src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
    logic [1:0]          size_q, size_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d, err_q, err_d, aborted_q, aborted_d;
    logic                abort_pend_q, abort_pend_d;
    logic [W_DATA-1:0]   data_q, data_d;
    logic                irq_q, irq_d;

    // APB decode
    logic       apb_acc, apb_wr, mapped, busy, wr_locked, wr_ok;
    logic [2:0] reg_idx;
    logic       start_req, abort_req, abort_eff, misalign;
    logic [1:0] new_size;
    logic [W_ADDR-1:0] step;
    logic [W_DATA-1:0] rd_shift, rd_lane;
    logic       unused_paddr;

    assign unused_paddr = ^paddr[1:0];

    assign apb_acc = psel & penable;
    assign apb_wr  = apb_acc & pwrite;
    assign reg_idx = paddr[4:2];
    assign mapped  = (paddr[15:5] == 11'd0) && (reg_idx <= 3'd5);
    assign busy    = (state_q != S_IDLE);
    // While busy only ABORT (CTRL[6]) and the W1C status bits may be written.
    assign wr_locked = busy && ((reg_idx <= 3'd2) || ((reg_idx == 3'd3) && (pwdata[5:0] != 6'd0)));
    assign wr_ok     = apb_wr & mapped & ~wr_locked;
    assign pslverr   = apb_acc & (~mapped | (pwrite & wr_locked));
    assign pready    = 1'b1;

    assign start_req = wr_ok && (reg_idx == 3'd3) && pwdata[0];
    assign abort_req = wr_ok && (reg_idx == 3'd3) && pwdata[6] && busy;
    assign abort_eff = abort_pend_q | abort_req;

    // START checks use the SIZE being written in the same access.
    assign new_size = pwdata[4:3];
    assign misalign = ((new_size == 2'd1) && (src_q[0] | dst_q[0])) ||
                      ((new_size == 2'd2) && ((src_q[1:0] != 2'd0) || (dst_q[1:0] != 2'd0)));

    assign step = W_ADDR'(1) << size_q;

    // Bring the addressed lane down to bit 0; half-words shift by 0 or 16.
    assign rd_shift = hrdata >> {src_q[1:0], 3'b000};
    always_comb begin
        rd_lane = hrdata;
        case (size_q)
            2'd0:    rd_lane = {{(W_DATA-8){1'b0}}, rd_shift[7:0]};
            2'd1:    rd_lane = {{(W_DATA-16){1'b0}}, rd_shift[15:0]};
            default: rd_lane = hrdata;
        endcase
    end

    always_comb begin
        prdata = 32'd0;
        if (apb_acc && mapped) begin
            case (reg_idx)
                3'd0:    prdata = 32'(src_q);
                3'd1:    prdata = 32'(dst_q);
                3'd2:    prdata = 32'(count_q);
                3'd3:    prdata = {26'd0, irq_en_q, size_q, dst_inc_q, src_inc_q, 1'b0};
                3'd4:    prdata = {28'd0, aborted_q, err_q, done_q, busy};
                3'd5:    prdata = 32'(remain_q);
                default: prdata = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        count_d      = count_q;
        src_inc_d    = src_inc_q;
        dst_inc_d    = dst_inc_q;
        size_d       = size_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        err_d        = err_q;
        aborted_d    = aborted_q;
        remain_d     = remain_q;
        abort_pend_d = abort_pend_q | abort_req;
        data_d       = data_q;
        irq_d        = irq_en_q & (done_q | err_q | aborted_q);

        if (wr_ok) begin
            case (reg_idx)
                3'd0: src_d   = W_ADDR'(pwdata);
                3'd1: dst_d   = W_ADDR'(pwdata);
                3'd2: count_d = pwdata[W_COUNT-1:0];
                3'd3: if (!busy) begin
                    src_inc_d = pwdata[1];
                    dst_inc_d = pwdata[2];
                    size_d    = pwdata[4:3];
                    irq_en_d  = pwdata[5];
                end
                3'd4: begin
                    done_d    = done_q    & ~pwdata[1];
                    err_d     = err_q     & ~pwdata[2];
                    aborted_d = aborted_q & ~pwdata[3];
                end
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    aborted_d = 1'b0;
                    remain_d  = count_q;
                    if ((new_size == 2'd3) || misalign) begin
                        err_d = 1'b1;
                    end else if (count_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RD_A;
                    end
                end
            end
            S_RD_A: if (hready) state_d = S_RD_D;
            S_RD_D: begin
                if (hresp) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (hready) begin
                    data_d = rd_lane;
                    if (abort_eff) begin
                        state_d   = S_IDLE;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = S_WR_A;
                    end
                end
            end
            S_WR_A: if (hready) state_d = S_WR_D;
            S_WR_D: begin
                if (hresp) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (hready) begin
                    remain_d = remain_q - W_COUNT'(1);
                    if (src_inc_q) src_d = src_q + step;
                    if (dst_inc_q) dst_d = dst_q + step;
                    if (abort_eff) begin
                        state_d   = S_IDLE;
                        aborted_d = 1'b1;
                    end else if (remain_q == W_COUNT'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RD_A;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) abort_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            count_q      <= '0;
            src_inc_q    <= 1'b0;
            dst_inc_q    <= 1'b0;
            size_q       <= 2'd0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            aborted_q    <= 1'b0;
            remain_q     <= '0;
            abort_pend_q <= 1'b0;
            data_q       <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            count_q      <= count_d;
            src_inc_q    <= src_inc_d;
            dst_inc_q    <= dst_inc_d;
            size_q       <= size_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
            aborted_q    <= aborted_d;
            remain_q     <= remain_d;
            abort_pend_q <= abort_pend_d;
            data_q       <= data_d;
            irq_q        <= irq_d;
        end
    end

    // AHB outputs are decoded from the state register only.
    assign htrans    = ((state_q == S_RD_A) || (state_q == S_WR_A)) ? 2'b10 : 2'b00;
    assign haddr     = (state_q == S_RD_A) ? src_q : (state_q == S_WR_A) ? dst_q : '0;
    assign hwrite    = (state_q == S_WR_A);
    assign hsize     = ((state_q == S_RD_A) || (state_q == S_WR_A)) ? {1'b0, size_q} : 3'd0;
    assign hburst    = 3'd0;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;
    assign irq       = irq_q;

    always_comb begin
        hwdata = '0;
        if ((state_q == S_WR_A) || (state_q == S_WR_D)) begin
            case (size_q)
                2'd0:    hwdata = {(W_DATA/8){data_q[7:0]}};
                2'd1:    hwdata = {(W_DATA/16){data_q[15:0]}};
                default: hwdata = data_q;
            endcase
        end
    end

endmodule
